// File: rtl/aircon_bargraph_ctrl_if.sv
// Panel-side signal bundle for the aircon bar-graph controller.
// The master drives the debounced switch levels; the slave (the controller)
// drives the LED bar and status outputs.
interface aircon_bargraph_ctrl_if #(
  parameter int MODES = 4,
  parameter int BAR_W = 8
);
  localparam int LW = $clog2(BAR_W + 1);

  logic [MODES-1:0] Thermo_In;
  logic             Turbo_In;
  logic             ErrClr_In;
  logic [BAR_W-1:0] BGraph_Out;
  logic [LW-1:0]    Level_Out;
  logic             Turbo_Out;
  logic             Err_Out;

  modport master (
    output Thermo_In, Turbo_In, ErrClr_In,
    input  BGraph_Out, Level_Out, Turbo_Out, Err_Out
  );

  modport slave (
    input  Thermo_In, Turbo_In, ErrClr_In,
    output BGraph_Out, Level_Out, Turbo_Out, Err_Out
  );
endinterface

// File: rtl/aircon_bargraph_ctrl.sv
// Aircon front-panel display controller.
// Decodes a one-hot mode into a target bar level, ramps a thermometer bar
// toward it one segment every RAMP_DIV cycles, adds a time-limited turbo
// boost, and latches an error when invalid mode codes persist.
module aircon_bargraph_ctrl #(
  parameter int MODES     = 4,
  parameter int BAR_W     = 8,
  parameter int RAMP_DIV  = 4,
  parameter int TURBO_CYC = 16,
  parameter int ERR_CNT   = 3
) (
  input  logic                 Clk_In,
  input  logic                 nRst_In,
  aircon_bargraph_ctrl_if.slave bus
);

  localparam int STEP = BAR_W / MODES;
  localparam int LW   = $clog2(BAR_W + 1);
  localparam int PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW   = $clog2(TURBO_CYC + 1);
  localparam int EW   = $clog2(ERR_CNT + 1);

  localparam logic [LW:0]   STEP_X  = (LW + 1)'(STEP);
  localparam logic [PW-1:0] PRE_TOP = PW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] TURBO_L = TW'(TURBO_CYC);
  localparam logic [EW-1:0] ERR_TOP = EW'(ERR_CNT);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_TURBO, S_ERR} state_t;

  state_t            state_q;
  logic [LW-1:0]     level_q;
  logic [PW-1:0]     presc_q;
  logic [TW-1:0]     turbo_cnt_q;
  logic [EW-1:0]     inv_cnt_q;
  logic [LW-1:0]     base_q;
  logic              turbo_prev_q;
  logic              turbo_q;
  logic              err_q;
  logic [BAR_W-1:0]  bgraph_q;

  logic              valid;
  logic              mode_on;
  logic              mode_off;
  logic              turbo_rise;
  logic              err_trig;
  logic [EW-1:0]     inv_cnt_inc;
  logic [LW-1:0]     dec_base;
  logic [LW-1:0]     eff_base;
  logic [LW-1:0]     target;
  logic [LW-1:0]     level_nxt;
  logic [PW-1:0]     presc_nxt;

  // Boosted level clipped to the physical bar length.
  function automatic logic [LW-1:0] sat_target(input logic [LW:0] sum);
    if (int'(sum) > BAR_W) return LW'(BAR_W);
    return sum[LW-1:0];
  endfunction

  // Thermometer code: the lowest lvl segments lit.
  function automatic logic [BAR_W-1:0] bar_of(input logic [LW-1:0] lvl);
    logic [BAR_W-1:0] b;
    for (int i = 0; i < BAR_W; i++) b[i] = (i < int'(lvl));
    return b;
  endfunction

  // Mode decode, glitch hold, target selection and ramp next-state.
  always_comb begin
    valid    = ($countones(bus.Thermo_In) <= 1);
    dec_base = '0;
    for (int k = 0; k < MODES; k++)
      if (bus.Thermo_In[k]) dec_base = LW'((k + 1) * STEP);
    eff_base   = valid ? dec_base : base_q;
    mode_on    = valid && (bus.Thermo_In != '0);
    mode_off   = valid && (bus.Thermo_In == '0);
    turbo_rise = bus.Turbo_In && !turbo_prev_q;

    inv_cnt_inc = (inv_cnt_q == ERR_TOP) ? inv_cnt_q : inv_cnt_q + 1'b1;
    err_trig    = !valid && (state_q != S_ERR) && (inv_cnt_inc == ERR_TOP);

    if (state_q == S_ERR) target = '0;
    else target = sat_target({1'b0, eff_base} + (turbo_q ? STEP_X : '0));

    level_nxt = level_q;
    presc_nxt = presc_q;
    if (state_q == S_ERR || err_trig) begin
      level_nxt = '0;
      presc_nxt = '0;
    end else if (level_q == target) begin
      presc_nxt = '0;
    end else if (presc_q == PRE_TOP) begin
      presc_nxt = '0;
      level_nxt = (level_q < target) ? level_q + 1'b1 : level_q - 1'b1;
    end else begin
      presc_nxt = presc_q + 1'b1;
    end
  end

  // Mode FSM with registered outputs; error latch outranks OFF, OFF outranks turbo.
  always_ff @(posedge Clk_In or negedge nRst_In) begin
    if (!nRst_In) begin
      state_q      <= S_OFF;
      level_q      <= '0;
      presc_q      <= '0;
      turbo_cnt_q  <= '0;
      inv_cnt_q    <= '0;
      base_q       <= '0;
      turbo_prev_q <= 1'b0;
      turbo_q      <= 1'b0;
      err_q        <= 1'b0;
      bgraph_q     <= '0;
    end else begin
      turbo_prev_q <= bus.Turbo_In;
      base_q       <= eff_base;
      inv_cnt_q    <= valid ? '0 : inv_cnt_inc;
      level_q      <= level_nxt;
      presc_q      <= presc_nxt;
      bgraph_q     <= bar_of(level_nxt);

      if (state_q == S_ERR) begin
        if (bus.ErrClr_In && valid) begin
          state_q <= S_OFF;
          err_q   <= 1'b0;
        end
      end else if (err_trig) begin
        state_q     <= S_ERR;
        err_q       <= 1'b1;
        turbo_q     <= 1'b0;
        turbo_cnt_q <= '0;
      end else if (mode_off && state_q != S_OFF) begin
        state_q     <= S_OFF;
        turbo_q     <= 1'b0;
        turbo_cnt_q <= '0;
      end else begin
        case (state_q)
          S_OFF: if (mode_on) state_q <= S_RUN;
          S_RUN: begin
            if (turbo_rise) begin
              state_q     <= S_TURBO;
              turbo_q     <= 1'b1;
              turbo_cnt_q <= TURBO_L;
            end
          end
          S_TURBO: begin
            if (!bus.Turbo_In || turbo_cnt_q == TW'(1)) begin
              state_q     <= S_RUN;
              turbo_q     <= 1'b0;
              turbo_cnt_q <= '0;
            end else begin
              turbo_cnt_q <= turbo_cnt_q - 1'b1;
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign bus.BGraph_Out = bgraph_q;
  assign bus.Level_Out  = level_q;
  assign bus.Turbo_Out  = turbo_q;
  assign bus.Err_Out    = err_q;

endmodule

// File: tb/tb_aircon_bargraph_ctrl.sv
// Bench for aircon_bargraph_ctrl: hand-computed vector table for the
// directed scenarios, plus randomized traffic against a behavioural model.
module tb_aircon_bargraph_ctrl;
  localparam int MODES     = 4;
  localparam int BAR_W     = 8;
  localparam int RAMP_DIV  = 4;
  localparam int TURBO_CYC = 16;
  localparam int ERR_CNT   = 3;
  localparam int STEP      = BAR_W / MODES;
  localparam int LW        = $clog2(BAR_W + 1);

  localparam int ST_OFF = 0, ST_RUN = 1, ST_TURBO = 2, ST_ERR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  aircon_bargraph_ctrl_if #(.MODES(MODES), .BAR_W(BAR_W)) bus ();

  aircon_bargraph_ctrl #(
    .MODES(MODES), .BAR_W(BAR_W), .RAMP_DIV(RAMP_DIV),
    .TURBO_CYC(TURBO_CYC), .ERR_CNT(ERR_CNT)
  ) dut (
    .Clk_In (clk),
    .nRst_In(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_st, m_lvl, m_tick, m_inv, m_base, m_left;
  bit m_turbo, m_err, m_prev;

  typedef struct {
    logic [MODES-1:0] th;
    bit               tu;
    bit               clr;
    int               ncyc;
    int               lvl;
    bit               turbo;
    bit               err;
    string            name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [MODES-1:0] th, input bit tu, input bit clr,
                              input int ncyc, input int lvl, input bit turbo,
                              input bit err, input string name);
    vec_t v;
    v.th = th; v.tu = tu; v.clr = clr; v.ncyc = ncyc;
    v.lvl = lvl; v.turbo = turbo; v.err = err; v.name = name;
    return v;
  endfunction

  task automatic model_reset();
    m_st = ST_OFF; m_lvl = 0; m_tick = 0; m_inv = 0; m_base = 0; m_left = 0;
    m_turbo = 0; m_err = 0; m_prev = 0;
  endtask

  // One clock of the display rules, using the state before the edge.
  task automatic model_step(input logic [MODES-1:0] th, input bit tu, input bit clr);
    bit valid;
    bit trig;
    int base, target, inv;
    valid = ($countones(th) <= 1);
    if (!valid)         base = m_base;
    else if (th == '0)  base = 0;
    else                base = ($clog2(int'(th)) + 1) * STEP;
    if (m_st == ST_ERR) target = 0;
    else begin
      target = base + (m_turbo ? STEP : 0);
      if (target > BAR_W) target = BAR_W;
    end
    inv  = valid ? 0 : m_inv + 1;
    trig = !valid && (m_st != ST_ERR) && (inv >= ERR_CNT);

    if (m_st == ST_ERR || trig) begin
      m_lvl = 0; m_tick = 0;
    end else if (m_lvl == target) begin
      m_tick = 0;
    end else begin
      m_tick++;
      if (m_tick == RAMP_DIV) begin
        m_tick = 0;
        m_lvl += (target > m_lvl) ? 1 : -1;
      end
    end

    if (m_st == ST_ERR) begin
      if (clr && valid) begin m_st = ST_OFF; m_err = 0; end
    end else if (trig) begin
      m_st = ST_ERR; m_err = 1; m_turbo = 0;
    end else if (valid && th == '0 && m_st != ST_OFF) begin
      m_st = ST_OFF; m_turbo = 0;
    end else if (m_st == ST_OFF) begin
      if (valid && th != '0) m_st = ST_RUN;
    end else if (m_st == ST_RUN) begin
      if (tu && !m_prev) begin m_st = ST_TURBO; m_turbo = 1; m_left = TURBO_CYC; end
    end else begin
      m_left--;
      if (m_left == 0 || !tu) begin m_st = ST_RUN; m_turbo = 0; end
    end

    m_inv  = (inv > ERR_CNT) ? ERR_CNT : inv;
    m_prev = tu;
    m_base = base;
  endtask

  task automatic check(input string name, input int lvl, input bit turbo, input bit err);
    logic [BAR_W-1:0] exp_bar;
    logic [LW-1:0]    exp_lvl;
    for (int i = 0; i < BAR_W; i++) exp_bar[i] = (i < lvl);
    exp_lvl = LW'(lvl);
    vectors++;
    if (bus.Level_Out !== exp_lvl || bus.BGraph_Out !== exp_bar ||
        bus.Turbo_Out !== turbo || bus.Err_Out !== err) begin
      miscompares++;
      $display("FAIL %s @%0t: got level=%0d bar=%h turbo=%b err=%b, want level=%0d bar=%h turbo=%b err=%b",
               name, $time, bus.Level_Out, bus.BGraph_Out, bus.Turbo_Out, bus.Err_Out,
               exp_lvl, exp_bar, turbo, err);
    end
  endtask

  // Apply inputs for one cycle (called #1 after a rising edge), then compare with the model.
  task automatic drive(input logic [MODES-1:0] th, input bit tu, input bit clr);
    bus.Thermo_In = th;
    bus.Turbo_In  = tu;
    bus.ErrClr_In = clr;
    model_step(th, tu, clr);
    @(posedge clk);
    #1;
    check("model", m_lvl, m_turbo, m_err);
  endtask

  initial begin
    logic [MODES-1:0] th;
    bit tu, clr;
    int r;

    bus.Thermo_In = '0;
    bus.Turbo_In  = 1'b0;
    bus.ErrClr_In = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("reset", 0, 0, 0);
    rst_n = 1'b1;

    // T1: asynchronous reset in the middle of a ramp
    for (int i = 0; i < 20; i++) drive(4'b0100, 0, 0);
    check("t1_level5", 5, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async", 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed scenarios, expectations worked out by hand from the display rules
    tbl.push_back(mk(4'b0100, 0, 0,  3, 0, 0, 0, "t2_no_step_yet"));
    tbl.push_back(mk(4'b0100, 0, 0,  1, 1, 0, 0, "t2_first_step"));
    tbl.push_back(mk(4'b0100, 0, 0, 20, 6, 0, 0, "t2_reach6"));
    tbl.push_back(mk(4'b0100, 0, 0,  5, 6, 0, 0, "t2_hold6"));
    tbl.push_back(mk(4'b0100, 1, 0,  1, 6, 1, 0, "t3_turbo_on"));
    tbl.push_back(mk(4'b0100, 1, 0,  4, 7, 1, 0, "t3_up7"));
    tbl.push_back(mk(4'b0100, 1, 0,  4, 8, 1, 0, "t3_up8"));
    tbl.push_back(mk(4'b0100, 1, 0,  7, 8, 1, 0, "t3_still_on"));
    tbl.push_back(mk(4'b0100, 1, 0,  1, 8, 0, 0, "t3_expire16"));
    tbl.push_back(mk(4'b0100, 1, 0,  4, 7, 0, 0, "t3_down7"));
    tbl.push_back(mk(4'b0100, 1, 0,  4, 6, 0, 0, "t3_down6"));
    tbl.push_back(mk(4'b0100, 1, 0, 10, 6, 0, 0, "t3_held_no_retrig"));
    tbl.push_back(mk(4'b0100, 0, 0,  1, 6, 0, 0, "t3_release"));
    tbl.push_back(mk(4'b0100, 1, 0,  1, 6, 1, 0, "t3_rearm"));
    tbl.push_back(mk(4'b0100, 0, 0,  1, 6, 0, 0, "t3_deassert_exit"));
    tbl.push_back(mk(4'b1000, 0, 0,  8, 8, 0, 0, "t4_mode3"));
    tbl.push_back(mk(4'b1000, 1, 0,  1, 8, 1, 0, "t4_turbo_on"));
    tbl.push_back(mk(4'b1000, 1, 0, 10, 8, 1, 0, "t4_saturated"));
    tbl.push_back(mk(4'b1000, 0, 0,  1, 8, 0, 0, "t4_turbo_off"));
    tbl.push_back(mk(4'b0110, 0, 0,  2, 8, 0, 0, "t5_glitch_held"));
    tbl.push_back(mk(4'b1000, 0, 0,  1, 8, 0, 0, "t5_valid_again"));
    tbl.push_back(mk(4'b1111, 0, 0,  2, 8, 0, 0, "t5_two_invalid"));
    tbl.push_back(mk(4'b1111, 0, 0,  1, 0, 0, 1, "t5_err_latch"));
    tbl.push_back(mk(4'b1111, 0, 1,  2, 0, 0, 1, "t5_clr_invalid"));
    tbl.push_back(mk(4'b0000, 0, 1,  1, 0, 0, 0, "t5_clr_valid"));
    tbl.push_back(mk(4'b0000, 0, 0,  3, 0, 0, 0, "t5_off"));
    tbl.push_back(mk(4'b0100, 0, 0, 24, 6, 0, 0, "t6_ramp6"));
    tbl.push_back(mk(4'b0100, 1, 0,  1, 6, 1, 0, "t6_turbo_on"));
    tbl.push_back(mk(4'b0000, 1, 0,  1, 6, 0, 0, "t6_drop_cancels"));
    tbl.push_back(mk(4'b0000, 1, 0,  3, 5, 0, 0, "t6_down5"));
    tbl.push_back(mk(4'b0000, 0, 0, 20, 0, 0, 0, "t6_down0"));

    foreach (tbl[n]) begin
      for (int c = 0; c < tbl[n].ncyc; c++) drive(tbl[n].th, tbl[n].tu, tbl[n].clr);
      check(tbl[n].name, tbl[n].lvl, tbl[n].turbo, tbl[n].err);
    end

    // Randomized traffic: sticky modes, occasional invalid codes, toggling turbo, sparse clears
    th = '0; tu = 0; clr = 0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) th = MODES'($urandom);
      else if (r >= 70) begin
        r = int'($urandom_range(0, MODES));
        th = (r == 0) ? '0 : MODES'(1 << (r - 1));
      end
      if ($urandom_range(0, 9) == 0) tu = ~tu;
      clr = ($urandom_range(0, 19) == 0);
      drive(th, tu, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
